// File: rtl/decrypt_feeder.sv
// decrypt_feeder: paces a TS byte stream and even/odd control-word loads into the decrypt core.
// Define DECRYPT_FEEDER_SYNC_CHECK_EN to drop packets whose first byte is not 0x47.
module decrypt_feeder #(
  parameter int PKT_LEN  = 188,
  parameter int KEY_GAP  = 12,
  parameter int BYTE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_sop,
  input  logic        cw_update,
  input  logic        cw_sel,
  input  logic [63:0] cw,
  output logic [63:0] ck,
  output logic        even_odd,
  output logic        key_en,
  output logic        en,
  output logic [7:0]  encrypted,
  output logic        pkt_done,
  output logic        len_err,
  output logic        sync_err,
  output logic [15:0] pkt_cnt
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_KEY_LOAD = 2'd1;
  localparam logic [1:0] S_KEY_WAIT = 2'd2;
  localparam logic [1:0] S_BYTE_GAP = 2'd3;

  localparam int BW   = $clog2(PKT_LEN + 1);
  localparam int WMAX = (KEY_GAP > BYTE_GAP) ? KEY_GAP : BYTE_GAP;
  localparam int WW   = $clog2(WMAX + 1);
  localparam logic [BW-1:0] LAST_POS = BW'(PKT_LEN);
  localparam logic [WW-1:0] KEY_LAST = WW'(KEY_GAP - 1);
  localparam logic [WW-1:0] GAP_LAST = WW'(BYTE_GAP - 1);

  logic [1:0]    state;
  logic [BW-1:0] byte_cnt;
  logic [BW-1:0] next_pos;
  logic [WW-1:0] wait_cnt;
  logic          pend_even;
  logic          pend_odd;
  logic [63:0]   cw_even;
  logic [63:0]   cw_odd;
  logic          at_start;
  logic          any_pending;
  logic          accept;
  logic          service;
  logic          restart;
  logic          last_byte;
  logic          drop_now;

  // Keys are only loaded on a packet boundary, so they never change inside a packet.
  assign at_start    = (byte_cnt == '0);
  assign any_pending = pend_even | pend_odd;
  assign in_ready    = ~rst & (state == S_IDLE) & ~(at_start & any_pending);
  assign accept      = in_valid & in_ready;
  assign service     = ~rst & (state == S_IDLE) & at_start & any_pending;
  assign restart     = in_sop & ~at_start;

  // NOTE: next_pos gets its default on the first line, so every path assigns it and no latch is inferred.
  always_comb begin
    next_pos = byte_cnt + 1'b1;
    if (restart) next_pos = BW'(1);
  end

  assign last_byte = (next_pos == LAST_POS);

`ifdef DECRYPT_FEEDER_SYNC_CHECK_EN
  logic first_byte;
  logic bad_sync;
  logic drop;

  assign first_byte = at_start | in_sop;
  assign bad_sync   = first_byte & (in_byte != 8'h47);
  assign drop_now   = first_byte ? bad_sync : drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop     <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= accept & bad_sync;
      if (accept) drop <= drop_now & ~last_byte;
    end
  end
`else
  assign drop_now = 1'b0;
  assign sync_err = 1'b0;
`endif

  // NOTE: every state register uses a non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      wait_cnt  <= '0;
      pend_even <= 1'b0;
      pend_odd  <= 1'b0;
      ck        <= '0;
      even_odd  <= 1'b0;
      key_en    <= 1'b0;
      en        <= 1'b0;
      encrypted <= '0;
      pkt_done  <= 1'b0;
      len_err   <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      key_en   <= 1'b0;
      en       <= 1'b0;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (service) begin
            state    <= S_KEY_LOAD;
            key_en   <= 1'b1;
            ck       <= pend_even ? cw_even : cw_odd;
            even_odd <= ~pend_even;
            if (pend_even) pend_even <= 1'b0;
            else           pend_odd  <= 1'b0;
          end else if (accept) begin
            state    <= S_BYTE_GAP;
            wait_cnt <= GAP_LAST;
            byte_cnt <= last_byte ? '0 : next_pos;
            len_err  <= restart;
            if (!drop_now) begin
              en        <= 1'b1;
              encrypted <= in_byte;
              pkt_done  <= last_byte;
              if (last_byte) pkt_cnt <= pkt_cnt + 16'd1;
            end
          end
        end
        S_KEY_LOAD: begin
          state    <= S_KEY_WAIT;
          wait_cnt <= KEY_LAST;
        end
        S_KEY_WAIT, S_BYTE_GAP: begin
          if (wait_cnt == '0) state <= S_IDLE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      // A fresh update beats a same-cycle service of its slot, so the new word is loaded afterwards.
      if (cw_update & ~cw_sel) pend_even <= 1'b1;
      if (cw_update &  cw_sel) pend_odd  <= 1'b1;
    end
  end

  // NOTE: the control-word slots are only read while their pending flag is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (cw_update & ~cw_sel) cw_even <= cw;
    if (cw_update &  cw_sel) cw_odd  <= cw;
  end
endmodule

// File: tb/tb_decrypt_feeder.sv
// tb_decrypt_feeder: randomized stimulus with a transaction-level reference model and a
// scoreboard monitor that pops one expected event per en or key_en strobe.
module tb_decrypt_feeder;
  localparam int PKT_LEN  = 188;
  localparam int KEY_GAP  = 12;
  localparam int BYTE_GAP = 1;
`ifdef DECRYPT_FEEDER_SYNC_CHECK_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = '0;
  logic        in_sop = 1'b0;
  logic        cw_update = 1'b0;
  logic        cw_sel = 1'b0;
  logic [63:0] cw = '0;
  logic [63:0] ck;
  logic        even_odd;
  logic        key_en;
  logic        en;
  logic [7:0]  encrypted;
  logic        pkt_done;
  logic        len_err;
  logic        sync_err;
  logic [15:0] pkt_cnt;

  decrypt_feeder #(.PKT_LEN(PKT_LEN), .KEY_GAP(KEY_GAP), .BYTE_GAP(BYTE_GAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .in_sop(in_sop), .cw_update(cw_update), .cw_sel(cw_sel), .cw(cw), .ck(ck),
    .even_odd(even_odd), .key_en(key_en), .en(en), .encrypted(encrypted),
    .pkt_done(pkt_done), .len_err(len_err), .sync_err(sync_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_key;
    logic [63:0] data;
    bit          odd;
    bit          done;
    bit          lerr;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   key_cyc_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   key_seen = 0, en_seen = 0, sync_seen = 0;
  int   key_cyc = 0, done_cyc = 0, upd_cyc = 0, ready_cyc = 0, last_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: packet position, packet count and the two pending key slots.
  int          m_pos = 0;
  int          m_pkts = 0;
  bit          m_pe = 1'b0, m_po = 1'b0, m_drop = 1'b0;
  logic [63:0] m_ce = '0, m_co = '0;
  int          exp_sync = 0;

  task automatic m_flush();
    if (m_pos != 0) return;
    if (m_pe) begin
      exp_q.push_back('{is_key: 1'b1, data: m_ce, odd: 1'b0, done: 1'b0, lerr: 1'b0, cnt: 16'd0});
      m_pe = 1'b0;
    end
    if (m_po) begin
      exp_q.push_back('{is_key: 1'b1, data: m_co, odd: 1'b1, done: 1'b0, lerr: 1'b0, cnt: 16'd0});
      m_po = 1'b0;
    end
  endtask

  task automatic m_cw(input bit sel, input logic [63:0] val);
    if (sel) begin m_co = val; m_po = 1'b1; end
    else     begin m_ce = val; m_pe = 1'b1; end
    m_flush();
  endtask

  task automatic m_byte(input logic [7:0] b, input bit sop);
    exp_t e;
    bit   first;
    bit   lerr;
    first = (m_pos == 0) || sop;
    lerr  = sop && (m_pos != 0);
    m_pos = lerr ? 1 : m_pos + 1;
    if (first) m_drop = SYNC_ON && (b != 8'h47);
    if (first && m_drop) exp_sync++;
    e = '{is_key: 1'b0, data: 64'(b), odd: 1'b0, done: (m_pos == PKT_LEN), lerr: lerr, cnt: 16'(m_pkts)};
    if (e.done) begin
      m_pos = 0;
      if (!m_drop) begin m_pkts++; e.cnt = 16'(m_pkts); end
    end
    if (!m_drop) exp_q.push_back(e);
    if (e.done) m_drop = 1'b0;
    m_flush();
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_pos = 0; m_pkts = 0; m_pe = 1'b0; m_po = 1'b0; m_drop = 1'b0;
  endtask

  // Monitor: consumes one expected event per strobe, independent of the stimulus process.
  initial begin : monitor
    exp_t e;
    bit   prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (sync_err) sync_seen++;
        if (en || key_en) check("strobe_overlap", 64'({en & key_en, en & prev_en}), 64'd0);
        if (!en && (pkt_done || len_err)) check("strobe_without_en", 64'({pkt_done, len_err}), 64'd0);
        if (key_en) begin
          check("key_expected", 64'(exp_q.size() > 0 && exp_q[0].is_key), 64'd1);
          if (exp_q.size() > 0 && exp_q[0].is_key) begin
            e = exp_q.pop_front();
            check("ck", ck, e.data);
            check("even_odd", 64'(even_odd), 64'(e.odd));
          end
          key_seen++;
          key_cyc = cyc;
          key_cyc_q.push_back(cyc);
        end
        if (en) begin
          check("byte_expected", 64'(exp_q.size() > 0 && !exp_q[0].is_key), 64'd1);
          if (exp_q.size() > 0 && !exp_q[0].is_key) begin
            e = exp_q.pop_front();
            check("encrypted", 64'(encrypted), e.data);
            check("pkt_done", 64'(pkt_done), 64'(e.done));
            check("len_err", 64'(len_err), 64'(e.lerr));
            check("pkt_cnt", 64'(pkt_cnt), 64'(e.cnt));
          end
          en_seen++;
          if (pkt_done) done_cyc = cyc;
        end
        prev_en = en;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; ready_cyc = cyc; end
    end
    check("ready_timeout", 64'(ok), 64'd1);
    tick();
  endtask

  task automatic wait_keys(input int target);
    for (int n = 0; n < 200 && key_seen < target; n++) @(negedge clk);
    check("key_timeout", 64'(key_seen >= target), 64'd1);
    tick();
  endtask

  task automatic cw_req(input bit sel, input logic [63:0] val);
    if (m_pos == 0) wait_ready();
    in_valid = 1'b0;
    cw_update = 1'b1; cw_sel = sel; cw = val;
    @(negedge clk);
    upd_cyc = cyc;
    tick();
    cw_update = 1'b0;
    m_cw(sel, val);
  endtask

  // Holds in_valid until accepted; an optional cw_update is driven in the accept cycle itself.
  task automatic send_byte(input logic [7:0] b, input bit sop, input bit upd = 1'b0,
                           input bit usel = 1'b0, input logic [63:0] uval = '0);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_byte = b; in_sop = sop;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        last_acc = cyc;
        if (upd) begin cw_update = 1'b1; cw_sel = usel; cw = uval; end
      end
      @(posedge clk);
      #1;
      cw_update = 1'b0;
      n++;
    end
    check("accept_timeout", 64'(acc), 64'd1);
    if (acc) begin
      m_byte(b, sop);
      if (upd) m_cw(usel, uval);
    end
    in_sop = 1'b0;
  endtask

  initial begin : stimulus
    int k0, first_acc, e0, restart_at;
    logic [63:0] val;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("in_ready_in_reset", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_ck", ck, 64'd0);
    check("reset_outputs", 64'({even_odd, key_en, en, encrypted, pkt_done, len_err, sync_err, pkt_cnt}), 64'd0);
    check("ready_after_reset", 64'(in_ready), 64'd1);
    tick();

    // Even key load: key_en two cycles after the update, in_ready back KEY_GAP+3 cycles after it
    k0 = key_seen;
    cw_req(1'b0, 64'h0123456789ABCDEF);
    wait_ready();
    check("key_count_even", 64'(key_seen - k0), 64'd1);
    check("key_latency", 64'(key_cyc - upd_cyc), 64'd2);
    check("ready_return", 64'(ready_cyc - upd_cyc), 64'(KEY_GAP + 3));

    // Back-to-back even then odd updates
    wait_ready();
    k0 = key_seen;
    cw_update = 1'b1; cw_sel = 1'b0; cw = 64'hA5A5_0000_1111_2222;
    tick();
    m_cw(1'b0, 64'hA5A5_0000_1111_2222);
    cw_sel = 1'b1; cw = 64'h5A5A_3333_4444_5555;
    tick();
    cw_update = 1'b0;
    m_cw(1'b1, 64'h5A5A_3333_4444_5555);
    wait_keys(k0 + 2);
    check("key_pair_spacing", 64'(key_cyc_q[key_cyc_q.size()-1] - key_cyc_q[key_cyc_q.size()-2]),
          64'(KEY_GAP + 2));

    // Full packet with in_valid held high
    wait_ready();
    first_acc = 0;
    for (int i = 0; i < PKT_LEN; i++) begin
      send_byte((i == 0) ? 8'h47 : 8'(i), i == 0);
      if (i == 0) first_acc = last_acc;
    end
    in_valid = 1'b0;
    check("pkt_span", 64'(last_acc - first_acc), 64'(2 * (PKT_LEN - 1)));

    // Key update together with byte 50: loaded only after the packet, two cycles after its last en
    k0 = key_seen;
    val = {$urandom, $urandom};
    for (int i = 0; i < PKT_LEN; i++)
      send_byte((i == 0) ? 8'h47 : 8'($urandom), i == 0, i == 49, 1'b1, val);
    in_valid = 1'b0;
    wait_keys(k0 + 1);
    check("key_after_pkt", 64'(key_cyc - done_cyc), 64'd2);

    // Short packet: in_sop on byte 100, then the restarted packet runs a full length
    for (int i = 0; i < 99 + PKT_LEN; i++)
      send_byte((i == 0 || i == 99) ? 8'h47 : 8'($urandom), i == 0 || i == 99);
    in_valid = 1'b0;

    // Random packets, idle gaps, mid-packet updates, occasional restarts
    for (int p = 0; p < 6; p++) begin
      restart_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, PKT_LEN - 1)) : -1;
      if ($urandom_range(0, 1) == 1) cw_req(1'($urandom), {$urandom, $urandom});
      for (int i = 0; i < PKT_LEN + ((restart_at > 0) ? restart_at : 0); i++) begin
        bit sop;
        bit upd;
        sop = (i == 0) || (i == restart_at);
        upd = !sop && m_pos >= 1 && m_pos <= PKT_LEN - 3 && $urandom_range(0, 39) == 0;
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
        end
        send_byte(sop ? 8'h47 : 8'($urandom), sop, upd, 1'($urandom), {$urandom, $urandom});
      end
      in_valid = 1'b0;
    end

`ifdef DECRYPT_FEEDER_SYNC_CHECK_EN
    // Bad sync byte: whole packet consumed silently, count unchanged
    e0 = en_seen;
    for (int i = 0; i < PKT_LEN; i++)
      send_byte((i == 0) ? 8'h46 : 8'($urandom), i == 0);
    in_valid = 1'b0;
    repeat (4) tick();
    check("dropped_en", 64'(en_seen - e0), 64'd0);
`endif

    // Reset during KEY_WAIT discards an outstanding odd key
    k0 = key_seen;
    cw_req(1'b0, 64'hFEED_FACE_CAFE_BEEF);
    wait_keys(k0 + 1);
    cw_update = 1'b1; cw_sel = 1'b1; cw = 64'h1234_5678_9ABC_DEF0;
    tick();
    cw_update = 1'b0;
    tick();
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    check("in_ready_in_reset2", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_ck2", ck, 64'd0);
    check("reset_outputs2", 64'({even_odd, key_en, en, encrypted, pkt_done, len_err, sync_err, pkt_cnt}), 64'd0);
    k0 = key_seen;
    repeat (30) tick();
    check("no_key_after_reset", 64'(key_seen), 64'(k0));
    check("ready_idle_after_reset", 64'(in_ready), 64'd1);

    // One packet after reset restarts pkt_cnt at 1
    for (int i = 0; i < PKT_LEN; i++)
      send_byte((i == 0) ? 8'h47 : 8'($urandom), i == 0);
    in_valid = 1'b0;
    repeat (20) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("sync_err_count", 64'(sync_seen), 64'(exp_sync));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
